core_alu_sched: RTL

CORE_ALU_SCHED -- requirements
Module: core_alu_sched

---
 rtl/core_alu_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/core_alu_sched.sv
// core_alu_sched
//
// Single-issue scheduler that sits between decode and a one-cycle ALU.
// An op is accepted in IDLE (or in WB while the writeback is being
// consumed). It spends one cycle in EXEC while the ALU computes. It then
// either resolves as a branch pulse, retires silently (rd = 0), or is
// parked in WB until the writeback port takes it. A read-after-write
// hazard against the op still in flight blocks issue, because no
// forwarding path exists.
//
// Parameters
//   STALL_W        width of the saturating stall counter
//
// Ports
//   CLK            clock, all state updates on the rising edge
//   RST            synchronous active-high reset
//   ISSUE_VALID    decode presents an op
//   ISSUE_READY    scheduler accepts the op this cycle
//   ISSUE_RD       destination register index
//   ISSUE_RS1/RS2  source register indices
//   ISSUE_USE_RS1/RS2  the corresponding source is actually read
//   ISSUE_BRANCH   op is a conditional branch, so it has no writeback
//   ALU_GO         loads the ALU operand register (equals the issue handshake)
//   ALU_RESULT     ALU output, valid the cycle after ALU_GO
//   WB_VALID/WB_READY/WB_RD/WB_DATA  writeback handshake
//   BR_VALID/BR_TAKEN  one-cycle branch-resolution pulse
//   FLUSH          kills the op currently in EXEC
//   STALL_CNT      saturating count of cycles with ISSUE_VALID=1 and ISSUE_READY=0

module core_alu_sched #(
    parameter int STALL_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ISSUE_VALID,
    output logic               ISSUE_READY,
    input  logic [4:0]         ISSUE_RD,
    input  logic [4:0]         ISSUE_RS1,
    input  logic [4:0]         ISSUE_RS2,
    input  logic               ISSUE_USE_RS1,
    input  logic               ISSUE_USE_RS2,
    input  logic               ISSUE_BRANCH,
    output logic               ALU_GO,
    input  logic [31:0]        ALU_RESULT,
    output logic               WB_VALID,
    input  logic               WB_READY,
    output logic [4:0]         WB_RD,
    output logic [31:0]        WB_DATA,
    output logic               BR_VALID,
    output logic               BR_TAKEN,
    input  logic               FLUSH,
    output logic [STALL_W-1:0] STALL_CNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] pend_rd;
    logic       pend_br;
    logic       hazard;
    logic       issue_go;

    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    // Only an op that will write a real register can cause a hazard. The
    // check is gated by ISSUE_VALID so that source fields of a non-op
    // cannot influence anything.
    assign hazard = ISSUE_VALID
                 && (state == EXEC || state == WB)
                 && (pend_rd != 5'd0) && !pend_br
                 && ((ISSUE_USE_RS1 && ISSUE_RS1 == pend_rd)
                  || (ISSUE_USE_RS2 && ISSUE_RS2 == pend_rd));

    // Accept in IDLE, or in WB on the cycle the writeback is consumed, so
    // that back-to-back ops run without a bubble.
    assign ISSUE_READY = !RST && !FLUSH && !hazard
                      && (state == IDLE || (state == WB && WB_READY));

    assign issue_go = ISSUE_VALID && ISSUE_READY;
    assign ALU_GO   = issue_go;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            pend_rd   <= 5'd0;
            pend_br   <= 1'b0;
            WB_VALID  <= 1'b0;
            WB_RD     <= 5'd0;
            WB_DATA   <= 32'd0;
            BR_VALID  <= 1'b0;
            BR_TAKEN  <= 1'b0;
            STALL_CNT <= '0;
        end else begin
            BR_VALID <= 1'b0;
            BR_TAKEN <= 1'b0;

            if (ISSUE_VALID && !ISSUE_READY && STALL_CNT != STALL_MAX) begin
                STALL_CNT <= STALL_CNT + STALL_ONE;
            end

            case (state)
                IDLE: begin
                    if (issue_go) begin
                        pend_rd <= ISSUE_RD;
                        pend_br <= ISSUE_BRANCH;
                        state   <= EXEC;
                    end
                end

                EXEC: begin
                    if (FLUSH) begin
                        state <= IDLE;
                    end else if (pend_br) begin
                        BR_VALID <= 1'b1;
                        BR_TAKEN <= ALU_RESULT[0];
                        state    <= IDLE;
                    end else if (pend_rd == 5'd0) begin
                        state <= IDLE;
                    end else begin
                        WB_VALID <= 1'b1;
                        WB_RD    <= pend_rd;
                        WB_DATA  <= ALU_RESULT;
                        state    <= WB;
                    end
                end

                WB: begin
                    // FLUSH does not reach an op that has already left EXEC.
                    if (WB_READY) begin
                        WB_VALID <= 1'b0;
                        if (issue_go) begin
                            pend_rd <= ISSUE_RD;
                            pend_br <= ISSUE_BRANCH;
                            state   <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
